// File: rtl/synth_voice_engine.sv
// synth_voice_engine: time-multiplexed phase-accumulator voices sharing one
// waveform/gain/mix datapath, producing one saturated 8-bit sample per frame.
module synth_voice_engine #(
   parameter  int unsigned NUM_VOICES = 4,
   parameter  int unsigned PHASE_W    = 24,
   parameter  int unsigned SAMPLE_DIV = 1024,
   localparam int unsigned VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ena,
   input  logic                  cfg_we,
   input  logic [VW+2:0]         cfg_addr,
   input  logic [7:0]            cfg_wdata,
   input  logic [NUM_VOICES-1:0] gate_in,
   output logic [7:0]            mix_out,
   output logic                  mix_valid,
   output logic [NUM_VOICES-1:0] sync_out,
   output logic                  busy
);

   localparam int unsigned CW = $clog2(SAMPLE_DIV);
   localparam int unsigned AW = 8 + VW;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_SAT  = 2'd2
   } state_t;

   // Frame sequencing and outputs
   state_t                r_state;
   logic [CW-1:0]         r_frame_cnt;
   logic [VW-1:0]         r_voice;
   logic [AW-1:0]         r_acc;
   logic [7:0]            r_mix_out;
   logic                  r_mix_valid;
   logic                  r_busy;
   logic [NUM_VOICES-1:0] r_sync_out;

   // Per-voice configuration
   logic [7:0]            r_freq_l [NUM_VOICES];
   logic [7:0]            r_freq_m [NUM_VOICES];
   logic [7:0]            r_freq_h [NUM_VOICES];
   logic [7:0]            r_duty   [NUM_VOICES];
   logic [7:0]            r_gain   [NUM_VOICES];
   logic [3:0]            r_ctrl   [NUM_VOICES];
   logic [NUM_VOICES-1:0] r_commit;
   logic [PHASE_W-1:0]    r_freq   [NUM_VOICES];
   logic [PHASE_W-1:0]    r_phase  [NUM_VOICES];

   // Gate synchronisation and sync requests
   logic [NUM_VOICES-1:0] r_gate_s1;
   logic [NUM_VOICES-1:0] r_gate_s2;
   logic [NUM_VOICES-1:0] r_gate_d;
   logic [NUM_VOICES-1:0] r_sync_pend;

   logic [VW-1:0]         w_cfg_voice;
   logic [2:0]            w_cfg_reg;
   logic                  w_cfg_hit;
   logic                  w_frame_start;
   logic                  w_slot;
   logic [NUM_VOICES-1:0] w_gate_rise;
   logic                  w_en;
   logic [1:0]            w_wave;
   logic [PHASE_W-1:0]    w_phase_nxt;
   logic [7:0]            w_p8;
   logic [7:0]            w_tri;
   logic [7:0]            w_samp;
   logic [15:0]           w_prod;
   logic [7:0]            w_scaled;

   assign w_cfg_voice   = cfg_addr[VW+2:3];
   assign w_cfg_reg     = cfg_addr[2:0];
   assign w_cfg_hit     = cfg_we && (32'(w_cfg_voice) < NUM_VOICES) && (w_cfg_reg <= 3'd5);
   assign w_frame_start = ena && (r_state == ST_IDLE) && (r_frame_cnt == '0);
   assign w_slot        = ena && (r_state == ST_SCAN);
   assign w_gate_rise   = r_gate_s2 & ~r_gate_d;

   assign mix_out   = r_mix_out;
   assign mix_valid = r_mix_valid;
   assign sync_out  = r_sync_out;
   assign busy      = r_busy;

   // Register writes; armed frequency shadows are copied to the active set at frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_commit <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_freq_l[v] <= '0;
            r_freq_m[v] <= '0;
            r_freq_h[v] <= '0;
            r_duty[v]   <= '0;
            r_gain[v]   <= '0;
            r_ctrl[v]   <= '0;
            r_freq[v]   <= '0;
         end
      end else begin
         if (w_frame_start) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
               if (r_commit[v]) begin
                  r_freq[v] <= PHASE_W'({r_freq_h[v], r_freq_m[v], r_freq_l[v]});
               end
            end
            r_commit <= '0;
         end
         // A FREQ_H write landing on the frame-start edge re-arms after the clear above
         if (w_cfg_hit) begin
            case (w_cfg_reg)
               3'd0: r_freq_l[w_cfg_voice] <= cfg_wdata;
               3'd1: r_freq_m[w_cfg_voice] <= cfg_wdata;
               3'd2: begin
                  r_freq_h[w_cfg_voice] <= cfg_wdata;
                  r_commit[w_cfg_voice] <= 1'b1;
               end
               3'd3: r_duty[w_cfg_voice] <= cfg_wdata;
               3'd4: r_ctrl[w_cfg_voice] <= cfg_wdata[3:0];
               3'd5: r_gain[w_cfg_voice] <= cfg_wdata;
               default: ;
            endcase
         end
      end
   end

   // Two-flop gate synchroniser plus a delayed copy for rising-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gate_s1 <= '0;
         r_gate_s2 <= '0;
         r_gate_d  <= '0;
      end else begin
         r_gate_s1 <= gate_in;
         r_gate_s2 <= r_gate_s1;
         r_gate_d  <= r_gate_s2;
      end
   end

   // Sync-pending flags: served slot clears, a new edge in the same cycle wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_pend <= '0;
      end else begin
         for (int v = 0; v < NUM_VOICES; v++) begin
            if (w_slot && (r_voice == VW'(v))) begin
               r_sync_pend[v] <= 1'b0;
            end
            if (w_gate_rise[v] && r_ctrl[v][3]) begin
               r_sync_pend[v] <= 1'b1;
            end
         end
      end
   end

   // Shared voice datapath for the slot currently being scanned
   always_comb begin
      w_en   = r_ctrl[r_voice][0];
      w_wave = r_ctrl[r_voice][2:1];
      if (r_sync_pend[r_voice]) begin
         w_phase_nxt = '0;
      end else if (w_en) begin
         w_phase_nxt = r_phase[r_voice] + r_freq[r_voice];
      end else begin
         w_phase_nxt = r_phase[r_voice];
      end
      w_p8   = w_phase_nxt[PHASE_W-1 -: 8];
      w_tri  = w_phase_nxt[PHASE_W-2 -: 8];
      w_samp = 8'h00;
      if (w_en) begin
         case (w_wave)
            2'd1:    w_samp = (w_p8 < r_duty[r_voice]) ? 8'hFF : 8'h00;
            2'd2:    w_samp = w_p8;
            2'd3:    w_samp = w_phase_nxt[PHASE_W-1] ? ~w_tri : w_tri;
            default: w_samp = 8'h00;
         endcase
      end
      // GAIN+1 multiplier so that 0xFF passes the sample unchanged
      w_prod   = 16'(w_samp) * 16'({1'b0, r_gain[r_voice]} + 9'd1);
      w_scaled = 8'(w_prod >> 8);
   end

   // Frame counter, IDLE/SCAN/SAT sequencer, phase update and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_frame_cnt <= '0;
         r_voice     <= '0;
         r_acc       <= '0;
         r_mix_out   <= '0;
         r_mix_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_sync_out  <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_phase[v] <= '0;
         end
      end else begin
         r_mix_valid <= 1'b0;
         if (ena) begin
            if (r_frame_cnt == CW'(SAMPLE_DIV - 1)) begin
               r_frame_cnt <= '0;
            end else begin
               r_frame_cnt <= r_frame_cnt + CW'(1);
            end
            case (r_state)
               ST_IDLE: begin
                  if (r_frame_cnt == '0) begin
                     r_state <= ST_SCAN;
                     r_voice <= '0;
                     r_acc   <= '0;
                     r_busy  <= 1'b1;
                  end
               end
               ST_SCAN: begin
                  r_phase[r_voice]    <= w_phase_nxt;
                  r_sync_out[r_voice] <= w_phase_nxt[PHASE_W-1];
                  r_acc               <= r_acc + AW'(w_scaled);
                  if (r_voice == VW'(NUM_VOICES - 1)) begin
                     r_state <= ST_SAT;
                  end else begin
                     r_voice <= r_voice + VW'(1);
                  end
               end
               ST_SAT: begin
                  r_mix_out   <= (r_acc > AW'(255)) ? 8'hFF : r_acc[7:0];
                  r_mix_valid <= 1'b1;
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_synth_voice_engine.sv
// Directed bench for synth_voice_engine: expected frame samples are queued as
// stimulus is applied and compared when mix_valid pulses.
module tb_synth_voice_engine;

   localparam int unsigned NV  = 4;
   localparam int unsigned PW  = 24;
   localparam int unsigned SD  = 64;
   localparam int unsigned VWL = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           ena;
   logic           cfg_we;
   logic [VWL+2:0] cfg_addr;
   logic [7:0]     cfg_wdata;
   logic [NV-1:0]  gate_in;
   logic [7:0]     mix_out;
   logic           mix_valid;
   logic [NV-1:0]  sync_out;
   logic           busy;

   int          checks    = 0;
   int          errors    = 0;
   int          ena_edges = 0;
   int          n_valid   = 0;
   bit          mon_on    = 1'b0;
   logic [7:0]  exp_q[$];

   synth_voice_engine #(
      .NUM_VOICES(NV),
      .PHASE_W   (PW),
      .SAMPLE_DIV(SD)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_wdata(cfg_wdata),
      .gate_in  (gate_in),
      .mix_out  (mix_out),
      .mix_valid(mix_valid),
      .sync_out (sync_out),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   // Count enabled clock edges since reset; edge index 0 mod SD is a frame start
   always @(posedge clk) begin
      if (!rst_n) ena_edges = 0;
      else if (ena) ena_edges++;
   end

   // Scoreboard pop and timing checks on every mix_valid pulse
   always @(negedge clk) begin : mon
      logic [7:0] e;
      if (mon_on && rst_n) begin
         if (mix_valid) begin
            n_valid++;
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("FAIL unexpected_valid: observed pulse with mix_out %02h, required no pulse", mix_out);
            end
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               checks++;
               assert (mix_out === e) else begin
                  errors++;
                  $error("FAIL mix_out: observed %02h required %02h", mix_out, e);
               end
            end
            checks++;
            assert ((ena_edges % SD) == NV + 2) else begin
               errors++;
               $error("FAIL valid_latency: observed edge %0d in frame, required %0d", ena_edges % SD, NV + 2);
            end
         end
         if ((ena_edges % SD) == 1) begin
            checks++;
            assert (busy === 1'b1) else begin
               errors++;
               $error("FAIL busy_scan: observed %0b required 1", busy);
            end
         end
         if ((ena_edges % SD) == NV + 2) begin
            checks++;
            assert (busy === 1'b0 && mix_valid === 1'b1) else begin
               errors++;
               $error("FAIL frame_end: observed busy %0b valid %0b, required busy 0 valid 1", busy, mix_valid);
            end
         end
      end
   end

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %02h required %02h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int v, input int r, input logic [7:0] d);
      cfg_we    = 1'b1;
      cfg_addr  = {VWL'(v), 3'(r)};
      cfg_wdata = d;
      @(negedge clk);
      cfg_we    = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 3 * SD && !seen; i++) begin
         @(negedge clk);
         if (mix_valid) seen = 1'b1;
      end
      checks++;
      assert (seen) else begin
         errors++;
         $error("FAIL %s: observed no mix_valid in %0d clocks, required a pulse", tag, 3 * SD);
      end
   endtask

   task automatic expect_frame(input logic [7:0] e, input string tag);
      exp_q.push_back(e);
      wait_valid(tag);
   endtask

   task automatic wait_count(input int unsigned target);
      int n;
      n = 0;
      while (((ena_edges % SD) != target) && n < 2 * SD) begin
         @(negedge clk);
         n++;
      end
      checks++;
      assert ((ena_edges % SD) == target) else begin
         errors++;
         $error("FAIL wait_count: observed position %0d required %0d", ena_edges % SD, target);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int nv0;
      rst_n = 1'b0; ena = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; gate_in = '0;
      repeat (3) @(negedge clk);
      chk8("rst_mix_out",   mix_out,         8'h00);
      chk8("rst_mix_valid", 8'(mix_valid),   8'h00);
      chk8("rst_sync_out",  8'(sync_out),    8'h00);
      chk8("rst_busy",      8'(busy),        8'h00);
      rst_n = 1'b1; ena = 1'b1; mon_on = 1'b1;

      // Idle frames
      for (int i = 0; i < 3; i++) expect_frame(8'h00, "idle");
      chk8("idle_sync", 8'(sync_out), 8'h00);

      // Saw ramp on voice 0
      wr(0, 0, 8'h00); wr(0, 1, 8'h00); wr(0, 2, 8'h10); wr(0, 4, 8'h05); wr(0, 5, 8'hFF);
      for (int i = 1; i <= 16; i++) expect_frame(8'(i * 16), "saw_ramp");

      // Half gain on saw, then triangle
      wr(0, 2, 8'h80); wr(0, 5, 8'h7F);
      expect_frame(8'h40, "saw_gain_7f");
      wr(0, 2, 8'h40); wr(0, 4, 8'h07); wr(0, 5, 8'hFF);
      expect_frame(8'h7F, "triangle_c0");

      // Four squares at phase 0 saturate
      wr(0, 3, 8'h80); wr(0, 4, 8'h03);
      for (int v = 1; v < 4; v++) begin
         wr(v, 3, 8'h80); wr(v, 4, 8'h03); wr(v, 5, 8'hFF);
      end
      expect_frame(8'hFF, "square_sat");
      chk8("square_sync", 8'(sync_out), 8'h00);
      wr(0, 4, 8'h00);
      for (int v = 1; v < 4; v++) wr(v, 5, 8'h3F);
      expect_frame(8'hBD, "mix_three");
      wr(1, 3, 8'h00);
      expect_frame(8'h7E, "duty_zero");

      // Frequency shadow and commit
      for (int v = 1; v < 4; v++) wr(v, 4, 8'h00);
      wr(0, 4, 8'h05); wr(0, 0, 8'h34); wr(0, 1, 8'h12);
      expect_frame(8'h40, "freq_lm_only");
      expect_frame(8'h80, "freq_lm_only2");
      wr(0, 2, 8'h10);
      expect_frame(8'h90, "freq_commit");
      expect_frame(8'hA0, "freq_commit2");
      exp_q.push_back(8'hB0);
      wait_count(0);
      wr(0, 2, 8'h20);
      wait_valid("freq_coincident");
      expect_frame(8'hD0, "freq_coincident2");
      chk8("sync_msb", 8'(sync_out), 8'h01);

      // Hard sync from gate
      wr(0, 4, 8'h0D);
      gate_in = 4'b0001;
      expect_frame(8'h00, "sync_zero");
      chk8("sync_zero_out", 8'(sync_out), 8'h00);
      gate_in = 4'b0000;
      expect_frame(8'h20, "after_sync");

      // Freeze mid-frame with ena low
      exp_q.push_back(8'h40);
      exp_q.push_back(8'h60);
      wait_count(3);
      ena = 1'b0;
      nv0 = n_valid;
      repeat (5000) @(negedge clk);
      checks++;
      assert (n_valid == nv0) else begin
         errors++;
         $error("FAIL freeze_valid: observed %0d pulses required %0d", n_valid - nv0, 0);
      end
      chk8("freeze_busy", 8'(busy), 8'h01);
      chk8("freeze_sync", 8'(sync_out), 8'h00);
      ena = 1'b1;
      wait_valid("resume");
      wait_valid("resume2");

      // Reset in the middle of a frame
      wait_count(3);
      rst_n = 1'b0;
      #1;
      chk8("midrst_mix_out", mix_out, 8'h00);
      chk8("midrst_busy", 8'(busy), 8'h00);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      expect_frame(8'h00, "post_reset");
      chk8("post_reset_sync", 8'(sync_out), 8'h00);

      @(negedge clk);
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL queue_drain: observed %0d pending required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
